// File: rtl/programmable_clock_divider.sv
`timescale 1ns/1ps
// programmable_clock_divider
//
// Produces a registered, glitch-free divided clock from one source clock.
// The ratio N (output period = N source cycles) can be changed at run time
// through a valid/ready handshake. A new ratio is held in a single pending
// slot and only loaded on an output period boundary:
//   - at the end of the LOW phase while running, or
//   - on the next edge while stopped.
// Because of this, no runt high or low phase is ever emitted.
//
// A ratio below 2 stops the output low. A ratio of 1 is treated as stop, so
// the output never toggles at the source frequency.
//
// Configuration macro: CLOCK_DIVIDER_DUTY_CORRECTION_EN
//   Undefined (default):
//     For odd N the high phase is ceil(N/2) cycles and the low phase is
//     floor(N/2) cycles.
//   Defined:
//     For odd N the registered high phase is shortened to floor(N/2)
//     cycles. A falling-edge flop then stretches it by half a source
//     cycle, which gives an exact 50% duty cycle.
//
// Parameters:
//   DIVIDER_WIDTH  width of the ratio field (ratios 0 .. 2^DIVIDER_WIDTH-1)
//   RESET_DIVIDER  ratio loaded at reset (<2: output stopped after reset)
//
// Ports:
//   clock          source clock
//   resetn         asynchronous active-low reset
//   divider        requested ratio N
//   divider_valid  request to update the ratio
//   divider_ready  high when a request can be accepted (no ratio pending)
//   clock_out      divided clock, driven from flops only
//   active         high when the divider is not stopped
module programmable_clock_divider #(
  parameter int DIVIDER_WIDTH = 8,
  parameter int RESET_DIVIDER = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [DIVIDER_WIDTH-1:0] divider,
  input  logic                     divider_valid,
  output logic                     divider_ready,
  output logic                     clock_out,
  output logic                     active
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_HIGH    = 2'd1;
  localparam logic [1:0] ST_LOW     = 2'd2;

  localparam logic [DIVIDER_WIDTH-1:0] ONE         = DIVIDER_WIDTH'(1);
  localparam logic [DIVIDER_WIDTH-1:0] TWO         = DIVIDER_WIDTH'(2);
  localparam logic [DIVIDER_WIDTH-1:0] RESET_RATIO = DIVIDER_WIDTH'(RESET_DIVIDER);

  // A running reset ratio starts in LOW with the counter already expired,
  // so the first edge after release is a period boundary and raises the
  // output.
  localparam logic [1:0] RESET_STATE = (RESET_DIVIDER >= 2) ? ST_LOW : ST_STOPPED;

  logic [DIVIDER_WIDTH-1:0] cur_q, cur_d;
  logic [DIVIDER_WIDTH-1:0] pend_q, pend_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]               state_q, state_d;
  logic                     clk_q, clk_d;

  logic                     boundary;
  logic [DIVIDER_WIDTH-1:0] next_ratio;

  // Registered high-phase length minus one, for ratio n >= 2.
  // half_lo + n[0] never overflows: for n = 2^W-1 it equals 2^(W-1).
  function automatic logic [DIVIDER_WIDTH-1:0] high_len_m1(
    input logic [DIVIDER_WIDTH-1:0] n
  );
    logic [DIVIDER_WIDTH-1:0] half_lo;
    logic [DIVIDER_WIDTH-1:0] half_hi;
    half_lo = n >> 1;
    half_hi = half_lo + {{(DIVIDER_WIDTH-1){1'b0}}, n[0]};
`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
    // For odd n, the negedge flop supplies the missing half cycle.
    return n[0] ? (half_lo - ONE) : (half_hi - ONE);
`else
    return half_hi - ONE;
`endif
  endfunction

  // Low-phase length minus one, for ratio n >= 2.
  function automatic logic [DIVIDER_WIDTH-1:0] low_len_m1(
    input logic [DIVIDER_WIDTH-1:0] n
  );
    logic [DIVIDER_WIDTH-1:0] half_lo;
    logic [DIVIDER_WIDTH-1:0] half_hi;
    half_lo = n >> 1;
    half_hi = half_lo + {{(DIVIDER_WIDTH-1){1'b0}}, n[0]};
`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
    return n[0] ? (half_hi - ONE) : (half_lo - ONE);
`else
    return half_lo - ONE;
`endif
  endfunction

  // A period boundary is either the last LOW cycle, or any cycle spent
  // stopped while a ratio is waiting.
  assign boundary   = ((state_q == ST_LOW) && (cnt_q == '0)) ||
                      ((state_q == ST_STOPPED) && pend_vld_q);
  assign next_ratio = pend_vld_q ? pend_q : cur_q;

  always_comb begin
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    state_d    = state_q;

    // Accept a request only when the slot is empty. A new request and the
    // clearing of the slot below can never happen in the same cycle.
    if (divider_valid && !pend_vld_q) begin
      pend_d     = divider;
      pend_vld_d = 1'b1;
    end

    if (boundary) begin
      if (pend_vld_q) begin
        cur_d      = pend_q;
        pend_vld_d = 1'b0;
      end
      if (next_ratio >= TWO) begin
        state_d = ST_HIGH;
        cnt_d   = high_len_m1(next_ratio);
      end else begin
        state_d = ST_STOPPED;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_HIGH: begin
          if (cnt_q == '0) begin
            state_d = ST_LOW;
            cnt_d   = low_len_m1(cur_q);
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_LOW: begin
          cnt_d = cnt_q - ONE;
        end
        ST_STOPPED: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_STOPPED;
          cnt_d   = '0;
        end
      endcase
    end

    // The output flop follows the next state, so each output edge is
    // registered on the same edge as the decision that causes it.
    clk_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_q      <= RESET_RATIO;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= RESET_STATE;
      clk_q      <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      clk_q      <= clk_d;
    end
  end

  assign divider_ready = !pend_vld_q;
  assign active        = (state_q != ST_STOPPED);

`ifdef CLOCK_DIVIDER_DUTY_CORRECTION_EN
  logic ext_q;

  // The negedge copy rises half a cycle after clk_q and falls half a cycle
  // after clk_q. Its high interval always overlaps the high interval of
  // clk_q, so the OR below has no glitch. The copy is enabled only for odd
  // ratios. Ratio loads happen while clk_q rises, and the first negedge
  // after a load already sees the new ratio.
  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      ext_q <= 1'b0;
    end else begin
      ext_q <= clk_q & cur_q[0];
    end
  end

  assign clock_out = clk_q | ext_q;
`else
  assign clock_out = clk_q;
`endif

endmodule
